packet_scheduler: RTL and testbench

//  Sequences the ADC sample stream into DMA S2MM packets: arms on ctrl_start, waits for trigger,

---
 rtl/packet_scheduler_pkg.sv | 17 +
 rtl/packet_scheduler.sv | 149 ++++++++++++++
 tb/tb_packet_scheduler.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/packet_scheduler_pkg.sv
// Shared types and defaults for the ADC-to-S2MM packet scheduler.
package packet_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        HDR,
        DATA,
        DONE
    } state_t;

    localparam logic [7:0] HDR_MAGIC  = 8'hA5;
    localparam int         DEF_DATA_W = 32;
    localparam int         DEF_LEN_W  = 16;
    localparam int         DEF_CNT_W  = 16;

endpackage

// File: rtl/packet_scheduler.sv
// Purpose: arms on start, waits for trigger, forwards N packets of L words with TLAST (optional header via PACKET_SCHEDULER_HEADER_EN).
// Latency: zero-cycle combinational pass-through of sample words in DATA; header word costs one beat.
// Backpressure: s_axis_tready follows m_axis_tready in DATA, held low in HDR, high (discard) otherwise.
module packet_scheduler
    import packet_scheduler_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [LEN_W-1:0]  cfg_pkt_len,
    input  logic [CNT_W-1:0]  cfg_pkt_count,
    input  logic              ctrl_start,
    input  logic              ctrl_stop,
    input  logic              trigger,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pkt_done_count,
    output logic [CNT_W-1:0]  stall_count
);

`ifdef PACKET_SCHEDULER_HEADER_EN
    localparam state_t PKT_ST = HDR;
`else
    localparam state_t PKT_ST = DATA;
`endif

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [LEN_W-1:0]   word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]   pkt_done_q, pkt_done_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic               stop_pend_q, stop_pend_d;

    logic               last_word;
    logic               run_complete;
    logic [DATA_W-1:0]  hdr_word;

    assign last_word    = (word_cnt_q == len_q - LEN_W'(1));
    assign run_complete = (count_q != '0) && ((pkt_done_q + CNT_W'(1)) == count_q);
    assign hdr_word     = DATA_W'({HDR_MAGIC, pkt_done_q[7:0], len_q});

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            len_q       <= LEN_W'(1);
            count_q     <= '0;
            word_cnt_q  <= '0;
            pkt_done_q  <= '0;
            stall_q     <= '0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            count_q     <= count_d;
            word_cnt_q  <= word_cnt_d;
            pkt_done_q  <= pkt_done_d;
            stall_q     <= stall_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        count_d       = count_q;
        word_cnt_d    = word_cnt_q;
        pkt_done_d    = pkt_done_q;
        stall_d       = stall_q;
        stop_pend_d   = stop_pend_q;
        s_axis_tready = 1'b1;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        done          = 1'b0;

        case (state_q)
            IDLE: begin
                stop_pend_d = 1'b0;
                if (ctrl_start) begin
                    len_d      = (cfg_pkt_len == '0) ? LEN_W'(1) : cfg_pkt_len;
                    count_d    = cfg_pkt_count;
                    word_cnt_d = '0;
                    pkt_done_d = '0;
                    stall_d    = '0;
                    state_d    = ARMED;
                end
            end
            ARMED: begin
                if (ctrl_stop) begin
                    state_d = DONE;
                end else if (trigger) begin
                    state_d = PKT_ST;
                end
            end
            HDR: begin
                s_axis_tready = 1'b0;
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = hdr_word;
                if (ctrl_stop) stop_pend_d = 1'b1;
                if (m_axis_tready) state_d = DATA;
            end
            DATA: begin
                m_axis_tvalid = s_axis_tvalid;
                s_axis_tready = m_axis_tready;
                m_axis_tdata  = s_axis_tdata;
                m_axis_tlast  = last_word;
                if (ctrl_stop) stop_pend_d = 1'b1;
                if (s_axis_tvalid && !m_axis_tready && (stall_q != '1)) begin
                    stall_d = stall_q + CNT_W'(1);
                end
                if (s_axis_tvalid && m_axis_tready) begin
                    if (last_word) begin
                        word_cnt_d = '0;
                        pkt_done_d = pkt_done_q + CNT_W'(1);
                        // A stop seen on the final beat itself still ends the run here.
                        if (stop_pend_q || ctrl_stop || run_complete) begin
                            state_d = DONE;
                        end else begin
                            state_d = PKT_ST;
                        end
                    end else begin
                        word_cnt_d = word_cnt_q + LEN_W'(1);
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy           = (state_q != IDLE);
    assign pkt_done_count = pkt_done_q;
    assign stall_count    = stall_q;

endmodule

// File: tb/tb_packet_scheduler.sv
// Directed self-checking bench for packet_scheduler; header test runs when PACKET_SCHEDULER_HEADER_EN is defined.
module tb_packet_scheduler;

    localparam int DW = 32;
    localparam int LW = 16;
    localparam int CW = 16;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [LW-1:0] cfg_pkt_len;
    logic [CW-1:0] cfg_pkt_count;
    logic          ctrl_start, ctrl_stop, trigger;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid, s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic          busy, done;
    logic [CW-1:0] pkt_done_count, stall_count;

    always #5 aclk = ~aclk;

    packet_scheduler #(.DATA_W(DW), .LEN_W(LW), .CNT_W(CW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cfg_pkt_len(cfg_pkt_len), .cfg_pkt_count(cfg_pkt_count),
        .ctrl_start(ctrl_start), .ctrl_stop(ctrl_stop), .trigger(trigger),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .busy(busy), .done(done),
        .pkt_done_count(pkt_done_count), .stall_count(stall_count)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] src_q[$];
    bit          src_en = 1'b0;
    bit          sink_toggle = 1'b0;
    logic [31:0] out_dat[$];
    bit          out_last[$];
    int          done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_src();
        if (src_en && src_q.size() > 0) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = src_q[0];
        end else begin
            s_axis_tvalid = 1'b0;
            s_axis_tdata  = '0;
        end
    endtask

    // Sample mid-cycle, then advance to just after the next rising edge.
    task automatic tick();
        @(negedge aclk);
        if (m_axis_tvalid && m_axis_tready) begin
            out_dat.push_back(m_axis_tdata);
            out_last.push_back(m_axis_tlast);
        end
        if (done) done_cnt++;
        if (s_axis_tvalid && s_axis_tready && src_q.size() > 0) void'(src_q.pop_front());
        @(posedge aclk);
        #1;
        if (sink_toggle) m_axis_tready = ~m_axis_tready;
        drive_src();
    endtask

    task automatic fill_src(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) src_q.push_back(base + 32'(i));
    endtask

    task automatic new_run(input logic [LW-1:0] len, input logic [CW-1:0] cnt);
        cfg_pkt_len   = len;
        cfg_pkt_count = cnt;
        ctrl_start    = 1'b1;
        tick();
        ctrl_start    = 1'b0;
        out_dat.delete();
        out_last.delete();
        done_cnt = 0;
    endtask

    task automatic fire_trigger();
        src_en  = 1'b0;
        drive_src();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        src_en  = 1'b1;
        drive_src();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic cleanup();
        src_en = 1'b0;
        src_q.delete();
        drive_src();
        sink_toggle   = 1'b0;
        m_axis_tready = 1'b1;
    endtask

    task automatic check_stream(input string tag, input logic [31:0] base, input int n, input int len);
        check({tag, "_nwords"}, 32'(out_dat.size()), 32'(n));
        for (int i = 0; i < n && i < out_dat.size(); i++) begin
            check($sformatf("%s_dat%0d", tag, i), out_dat[i], base + 32'(i));
            check($sformatf("%s_last%0d", tag, i), 32'(out_last[i]), 32'((i % len) == len - 1));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},   32'(busy), 32'd0);
        check({tag, "_done"},   32'(done), 32'd0);
        check({tag, "_mvld"},   32'(m_axis_tvalid), 32'd0);
        check({tag, "_mlast"},  32'(m_axis_tlast), 32'd0);
        check({tag, "_mdat"},   m_axis_tdata, 32'd0);
        check({tag, "_srdy"},   32'(s_axis_tready), 32'd1);
        check({tag, "_pktcnt"}, 32'(pkt_done_count), 32'd0);
        check({tag, "_stall"},  32'(stall_count), 32'd0);
    endtask

    initial begin
        aresetn       = 1'b1;
        cfg_pkt_len   = '0;
        cfg_pkt_count = '0;
        ctrl_start    = 1'b0;
        ctrl_stop     = 1'b0;
        trigger       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b1;
        #1 aresetn = 1'b0;
        tick();
        tick();
        check_reset_vals("rst");
        aresetn = 1'b1;
        tick();

        // 1: two packets of four words, sink always ready
        new_run(16'd4, 16'd2);
        fill_src(32'h100, 8);
        fire_trigger();
        wait_idle("t1");
        check_stream("t1", 32'h100, 8, 4);
        check("t1_done", 32'(done_cnt), 32'd1);
        check("t1_pktcnt", 32'(pkt_done_count), 32'd2);
        check("t1_stall", 32'(stall_count), 32'd0);
        cleanup();

        // 2: sink ready toggles from 0 on the first data cycle -> three stall cycles
        new_run(16'd3, 16'd1);
        fill_src(32'h200, 3);
        fire_trigger();
        m_axis_tready = 1'b0;
        sink_toggle   = 1'b1;
        wait_idle("t2");
        check_stream("t2", 32'h200, 3, 3);
        check("t2_stall", 32'(stall_count), 32'd3);
        check("t2_pktcnt", 32'(pkt_done_count), 32'd1);
        cleanup();

        // 3: continuous mode, stop while word 2 of packet 3 is on the bus
        new_run(16'd5, 16'd0);
        fill_src(32'h300, 25);
        fire_trigger();
        for (int n = 0; n < 200 && out_dat.size() < 11; n++) tick();
        ctrl_stop = 1'b1;
        tick();
        ctrl_stop = 1'b0;
        wait_idle("t3");
        check_stream("t3", 32'h300, 15, 5);
        check("t3_done", 32'(done_cnt), 32'd1);
        check("t3_pktcnt", 32'(pkt_done_count), 32'd3);
        cleanup();

        // 4: words offered while armed are discarded
        new_run(16'd2, 16'd1);
        src_q.push_back(32'h11);
        src_q.push_back(32'h22);
        src_en = 1'b1;
        drive_src();
        tick();
        tick();
        check("t4_drained", 32'(src_q.size()), 32'd0);
        check("t4_armed_busy", 32'(busy), 32'd1);
        fill_src(32'h400, 2);
        fire_trigger();
        wait_idle("t4");
        check_stream("t4", 32'h400, 2, 2);
        cleanup();

        // 5: reset mid-packet, then a clean restart
        new_run(16'd8, 16'd1);
        fill_src(32'h500, 8);
        fire_trigger();
        for (int n = 0; n < 50 && out_dat.size() < 2; n++) tick();
        check("t5_partial_n", 32'(out_dat.size()), 32'd2);
        check("t5_nolast", 32'(out_last.size() > 1 ? (out_last[0] | out_last[1]) : 1'b1), 32'd0);
        aresetn = 1'b0;
        #1;
        check_reset_vals("t5_rst_async");
        tick();
        check_reset_vals("t5_rst_edge");
        aresetn = 1'b1;
        cleanup();
        tick();
        new_run(16'd2, 16'd1);
        fill_src(32'h580, 2);
        fire_trigger();
        wait_idle("t5b");
        check_stream("t5b", 32'h580, 2, 2);
        cleanup();

        // 7: zero length behaves as one-word packets
        new_run(16'd0, 16'd2);
        fill_src(32'h700, 2);
        fire_trigger();
        wait_idle("t7");
        check_stream("t7", 32'h700, 2, 1);
        check("t7_pktcnt", 32'(pkt_done_count), 32'd2);
        cleanup();

        // 8: start and stop together arms; a later stop in ARMED ends the run empty
        cfg_pkt_len   = 16'd4;
        cfg_pkt_count = 16'd1;
        ctrl_start    = 1'b1;
        ctrl_stop     = 1'b1;
        tick();
        ctrl_start    = 1'b0;
        ctrl_stop     = 1'b0;
        out_dat.delete();
        out_last.delete();
        done_cnt = 0;
        tick();
        check("t8_armed", 32'(busy), 32'd1);
        ctrl_stop = 1'b1;
        tick();
        ctrl_stop = 1'b0;
        wait_idle("t8");
        check("t8_done", 32'(done_cnt), 32'd1);
        check("t8_nwords", 32'(out_dat.size()), 32'd0);
        cleanup();

`ifdef PACKET_SCHEDULER_HEADER_EN
        // 6: header word ahead of each packet
        begin
            logic [31:0] exp_d[6];
            bit          exp_l[6];
            exp_d = '{32'hA500_0002, 32'h600, 32'h601, 32'hA501_0002, 32'h602, 32'h603};
            exp_l = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
            new_run(16'd2, 16'd2);
            fill_src(32'h600, 4);
            fire_trigger();
            wait_idle("t6");
            check("t6_nwords", 32'(out_dat.size()), 32'd6);
            for (int i = 0; i < 6 && i < out_dat.size(); i++) begin
                check($sformatf("t6_dat%0d", i), out_dat[i], exp_d[i]);
                check($sformatf("t6_last%0d", i), 32'(out_last[i]), 32'(exp_l[i]));
            end
            cleanup();
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
